// File: rtl/fetch_pkg.sv
// Shared constants and types for the instruction-fetch stage.
// Address/instruction width, reset PC default, NOP encoding and next-PC select.
package fetch_pkg;

  localparam int XLEN = 32;

  localparam logic [XLEN-1:0] RESET_PC_DEF = 32'h0000_3000;
  localparam logic [XLEN-1:0] NOP_INSTR    = 32'h0000_0000;

  typedef enum logic [1:0] {
    PC_SEQ,
    PC_REDIRECT,
    PC_HOLD
  } pc_sel_e;

  // Branch targets are word-aligned; the low two bits are dropped.
  function automatic logic [XLEN-1:0] align_word(input logic [XLEN-1:0] addr);
    return {addr[XLEN-1:2], 2'b00};
  endfunction

endpackage

// File: rtl/fetch_stage_if_id_reg.sv
// IF/ID pipeline register: flush inserts a NOP bubble, stall holds all fields,
// otherwise the fetched instruction and its PCs are captured as valid.
module if_id_reg
  import fetch_pkg::*;
(
  input  logic            clk,
  input  logic            rst,
  input  logic            flush_i,
  input  logic            stall_i,
  input  logic [XLEN-1:0] instr_i,
  input  logic [XLEN-1:0] pc_i,
  input  logic [XLEN-1:0] pc4_i,
  output logic            valid_o,
  output logic [XLEN-1:0] instr_o,
  output logic [XLEN-1:0] pc_o,
  output logic [XLEN-1:0] pc4_o
);

  logic            valid_q, valid_d;
  logic [XLEN-1:0] instr_q, instr_d;
  logic [XLEN-1:0] pc_q,    pc_d;
  logic [XLEN-1:0] pc4_q,   pc4_d;

  // NOTE: every output of a combinational block gets a default first, so no
  // path leaves it unassigned and no latch is inferred.
  always_comb begin
    valid_d = valid_q;
    instr_d = instr_q;
    pc_d    = pc_q;
    pc4_d   = pc4_q;
    if (flush_i) begin
      valid_d = 1'b0;
      instr_d = NOP_INSTR;
      pc_d    = '0;
      pc4_d   = '0;
    end else if (!stall_i) begin
      valid_d = 1'b1;
      instr_d = instr_i;
      pc_d    = pc_i;
      pc4_d   = pc4_i;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q <= 1'b0;
      instr_q <= NOP_INSTR;
      pc_q    <= '0;
      pc4_q   <= '0;
    end else begin
      valid_q <= valid_d;
      instr_q <= instr_d;
      pc_q    <= pc_d;
      pc4_q   <= pc4_d;
    end
  end

  assign valid_o = valid_q;
  assign instr_o = instr_q;
  assign pc_o    = pc_q;
  assign pc4_o   = pc4_q;

endmodule

// File: rtl/fetch_stage.sv
// Instruction-fetch stage: PC register, next-PC selection (redirect > stall >
// sequential), imem addressing and the IF/ID register with a fetch counter.
module fetch_stage
  import fetch_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC = RESET_PC_DEF
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            stall_i,
  input  logic            redirect_valid_i,
  input  logic [XLEN-1:0] redirect_pc_i,
  output logic [XLEN-1:0] imem_addr_o,
  input  logic [XLEN-1:0] imem_rdata_i,
  output logic            if_id_valid_o,
  output logic [XLEN-1:0] if_id_instr_o,
  output logic [XLEN-1:0] if_id_pc_o,
  output logic [XLEN-1:0] if_id_pc4_o,
  output logic [XLEN-1:0] fetch_count_o
);

  logic [XLEN-1:0] pc_q, pc_d;
  logic [XLEN-1:0] pc_plus4;
  logic [XLEN-1:0] count_q, count_d;
  pc_sel_e         pc_sel;
  logic            load_valid;

  assign pc_plus4   = pc_q + 32'd4;
  assign load_valid = !redirect_valid_i && !stall_i;

  // Redirect outranks stall so a resolved branch is never lost.
  always_comb begin
    pc_sel = PC_SEQ;
    if (redirect_valid_i) begin
      pc_sel = PC_REDIRECT;
    end else if (stall_i) begin
      pc_sel = PC_HOLD;
    end
  end

  always_comb begin
    pc_d = pc_plus4;
    case (pc_sel)
      PC_REDIRECT: pc_d = align_word(redirect_pc_i);
      PC_HOLD:     pc_d = pc_q;
      default:     pc_d = pc_plus4;
    endcase
  end

  assign count_d = count_q + {{(XLEN-1){1'b0}}, load_valid};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc_q    <= RESET_PC;
      count_q <= '0;
    end else begin
      pc_q    <= pc_d;
      count_q <= count_d;
    end
  end

  if_id_reg u_if_id_reg (
    .clk     (clk),
    .rst     (rst),
    .flush_i (redirect_valid_i),
    .stall_i (stall_i),
    .instr_i (imem_rdata_i),
    .pc_i    (pc_q),
    .pc4_i   (pc_plus4),
    .valid_o (if_id_valid_o),
    .instr_o (if_id_instr_o),
    .pc_o    (if_id_pc_o),
    .pc4_o   (if_id_pc4_o)
  );

  assign imem_addr_o   = pc_q;
  assign fetch_count_o = count_q;

endmodule

// File: tb/tb_fetch_stage.sv
// Scoreboard bench for fetch_stage: stimulus pushes hand-computed post-edge
// expectations, a monitor pops and compares them after each rising edge.
module tb_fetch_stage;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        stall = 1'b0;
  logic        redir = 1'b0;
  logic [31:0] redir_pc = 32'h0;
  logic [31:0] imem_addr, imem_rdata;
  logic        v;
  logic [31:0] instr, ifpc, pc4, cnt;

  logic        rst_w = 1'b0;
  logic        stall_w = 1'b0;
  logic        redir_w = 1'b0;
  logic [31:0] redir_pc_w = 32'h0;
  logic [31:0] imem_addr_w, imem_rdata_w;
  logic        v_w;
  logic [31:0] instr_w, ifpc_w, pc4_w, cnt_w;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  typedef struct {
    int          tag;
    string       name;
    logic [31:0] pc;
    logic        v;
    logic [31:0] instr;
    logic [31:0] ifpc;
    logic [31:0] pc4;
    logic [31:0] cnt;
  } exp_t;

  exp_t sb[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [31:0] imem_fn(input logic [31:0] a);
    case (a)
      32'h0000_3000: imem_fn = 32'h0000_0011;
      32'h0000_3004: imem_fn = 32'h0000_0022;
      32'h0000_3008: imem_fn = 32'h0000_0033;
      32'h0000_300C: imem_fn = 32'h0000_0044;
      32'h0000_3100: imem_fn = 32'h0000_00A0;
      32'h0000_3104: imem_fn = 32'h0000_00A1;
      32'h0000_3200: imem_fn = 32'h0000_00B0;
      32'hFFFF_FFF8: imem_fn = 32'h0000_00F8;
      32'hFFFF_FFFC: imem_fn = 32'h0000_00FC;
      default:       imem_fn = 32'hDEAD_0000 | {16'h0, a[15:0]};
    endcase
  endfunction

  assign imem_rdata   = imem_fn(imem_addr);
  assign imem_rdata_w = imem_fn(imem_addr_w);

  fetch_stage dut (
    .clk              (clk),
    .rst              (rst),
    .stall_i          (stall),
    .redirect_valid_i (redir),
    .redirect_pc_i    (redir_pc),
    .imem_addr_o      (imem_addr),
    .imem_rdata_i     (imem_rdata),
    .if_id_valid_o    (v),
    .if_id_instr_o    (instr),
    .if_id_pc_o       (ifpc),
    .if_id_pc4_o      (pc4),
    .fetch_count_o    (cnt)
  );

  fetch_stage #(.RESET_PC(32'hFFFF_FFF8)) dut_w (
    .clk              (clk),
    .rst              (rst_w),
    .stall_i          (stall_w),
    .redirect_valid_i (redir_w),
    .redirect_pc_i    (redir_pc_w),
    .imem_addr_o      (imem_addr_w),
    .imem_rdata_i     (imem_rdata_w),
    .if_id_valid_o    (v_w),
    .if_id_instr_o    (instr_w),
    .if_id_pc_o       (ifpc_w),
    .if_id_pc4_o      (pc4_w),
    .fetch_count_o    (cnt_w)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic check_reset(input string name);
    check({name, ".addr"},  imem_addr, 32'h0000_3000);
    check({name, ".valid"}, {31'h0, v}, 32'h0);
    check({name, ".instr"}, instr, 32'h0);
    check({name, ".pc"},    ifpc, 32'h0);
    check({name, ".pc4"},   pc4, 32'h0);
    check({name, ".count"}, cnt, 32'h0);
  endtask

  // Drive one cycle's inputs at a falling edge and queue the state expected
  // right after the following rising edge; returns at the next falling edge.
  task automatic step(input logic st, input logic rv, input logic [31:0] rpc,
                      input string name, input logic [31:0] e_pc, input logic e_v,
                      input logic [31:0] e_instr, input logic [31:0] e_ifpc,
                      input logic [31:0] e_pc4, input logic [31:0] e_cnt);
    exp_t e;
    stall    = st;
    redir    = rv;
    redir_pc = rpc;
    e.tag = cyc + 1; e.name = name; e.pc = e_pc; e.v = e_v;
    e.instr = e_instr; e.ifpc = e_ifpc; e.pc4 = e_pc4; e.cnt = e_cnt;
    sb.push_back(e);
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (sb.size() > 0) begin
        if (sb[0].tag == cyc) begin
          e = sb.pop_front();
          check({e.name, ".addr"},  imem_addr, e.pc);
          check({e.name, ".valid"}, {31'h0, v}, {31'h0, e.v});
          check({e.name, ".instr"}, instr, e.instr);
          check({e.name, ".pc"},    ifpc, e.ifpc);
          check({e.name, ".pc4"},   pc4, e.pc4);
          check({e.name, ".count"}, cnt, e.cnt);
        end else if (sb[0].tag < cyc) begin
          e = sb.pop_front();
          check({e.name, ".stale"}, cyc, e.tag);
        end
      end
    end
  end

  initial begin : watchdog
    #100000;
    $display("FAIL watchdog: time limit reached, summary total=%0d bad=%0d", total, bad);
    $fatal(1, "timeout");
  end

  initial begin : stim
    #1 rst = 1'b1; rst_w = 1'b1;
    #1 check_reset("reset");
    check("reset_w.addr", imem_addr_w, 32'hFFFF_FFF8);
    repeat (2) @(negedge clk);
    check_reset("reset_held");
    rst = 1'b0;

    //   st  rv  rpc            name       pc            v  instr  ifpc          pc4           cnt
    step(0, 0, 32'h0, "run0",   32'h3004, 1, 32'h11, 32'h3000, 32'h3004, 32'd1);
    step(0, 0, 32'h0, "run1",   32'h3008, 1, 32'h22, 32'h3004, 32'h3008, 32'd2);
    step(0, 0, 32'h0, "run2",   32'h300C, 1, 32'h33, 32'h3008, 32'h300C, 32'd3);
    step(0, 0, 32'h0, "run3",   32'h3010, 1, 32'h44, 32'h300C, 32'h3010, 32'd4);
    // Misaligned redirect back to the start, then stall while PC = 0x3008.
    step(0, 1, 32'h3003, "rd0", 32'h3000, 0, 32'h0,  32'h0,    32'h0,    32'd4);
    step(0, 0, 32'h0, "rd0a",   32'h3004, 1, 32'h11, 32'h3000, 32'h3004, 32'd5);
    step(0, 0, 32'h0, "rd0b",   32'h3008, 1, 32'h22, 32'h3004, 32'h3008, 32'd6);
    step(1, 0, 32'h0, "stl0",   32'h3008, 1, 32'h22, 32'h3004, 32'h3008, 32'd6);
    step(1, 0, 32'h0, "stl1",   32'h3008, 1, 32'h22, 32'h3004, 32'h3008, 32'd6);
    step(1, 0, 32'h0, "stl2",   32'h3008, 1, 32'h22, 32'h3004, 32'h3008, 32'd6);
    step(0, 0, 32'h0, "resume", 32'h300C, 1, 32'h33, 32'h3008, 32'h300C, 32'd7);
    // Redirect at PC 0x300C to 0x3103 -> 0x3100 with one bubble.
    step(0, 1, 32'h3103, "rd1", 32'h3100, 0, 32'h0,  32'h0,    32'h0,    32'd7);
    step(0, 0, 32'h0, "rd1a",   32'h3104, 1, 32'hA0, 32'h3100, 32'h3104, 32'd8);
    // Redirect and stall together: redirect wins on PC, IF/ID bubbles.
    step(1, 1, 32'h3200, "rdst",32'h3200, 0, 32'h0,  32'h0,    32'h0,    32'd8);
    step(0, 0, 32'h0, "rdsta",  32'h3204, 1, 32'hB0, 32'h3200, 32'h3204, 32'd9);
    step(1, 0, 32'h0, "stl3",   32'h3204, 1, 32'hB0, 32'h3200, 32'h3204, 32'd9);

    // Asynchronous reset between edges while stalled.
    #1 rst = 1'b1;
    #1 check_reset("async_rst");
    #1 rst = 1'b0;
    step(0, 0, 32'h0, "rst0",   32'h3004, 1, 32'h11, 32'h3000, 32'h3004, 32'd1);
    step(0, 0, 32'h0, "rst1",   32'h3008, 1, 32'h22, 32'h3004, 32'h3008, 32'd2);

    repeat (4) begin
      if (sb.size() == 0) break;
      @(posedge clk);
      #2;
    end
    check("sb_drain", sb.size(), 32'd0);

    // Wrap-around from RESET_PC = 0xFFFF_FFF8.
    @(negedge clk);
    rst_w = 1'b0;
    check("wrap0.addr", imem_addr_w, 32'hFFFF_FFF8);
    @(posedge clk); #1;
    check("wrap1.addr",  imem_addr_w, 32'hFFFF_FFFC);
    check("wrap1.instr", instr_w, 32'hF8);
    check("wrap1.pc4",   pc4_w, 32'hFFFF_FFFC);
    @(posedge clk); #1;
    check("wrap2.addr",  imem_addr_w, 32'h0000_0000);
    check("wrap2.valid", {31'h0, v_w}, 32'h1);
    check("wrap2.pc",    ifpc_w, 32'hFFFF_FFFC);
    check("wrap2.pc4",   pc4_w, 32'h0000_0000);
    check("wrap2.count", cnt_w, 32'd2);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
